mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Shares the core's single memory port between the fetch stage's instruction bus and the memory stage's data bus. One transaction is in flight at a time. Data requests win by default; a starvation counter bounds how long fetch can be held off. The block sits between the pipeline's `ibus`/`dbus` ports and the downstream `cbus` toward cache/memory.

## Interface
- `MAX_WAIT`, default 4: idle-arbitration cycles an ibus request may lose to dbus before ibus is forced to win.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `ibus_req` in `ibus_req_t`: fetch request `{valid, addr}`; valid is held until response.
- `ibus_flush` in 1: fetch has redirected; the pending or in-flight fetch result is stale.
- `ibus_resp` out `ibus_resp_t`: `{addr_ok, data_ok, data[31:0]}`.
- `dbus_req` in `dbus_req_t`: `{valid, is_write, addr, size, strobe, data}`.
- `dbus_resp` out `dbus_resp_t`: `{addr_ok, data_ok, data[63:0]}`.
- `cbus_req` out `cbus_req_t`: `{valid, is_write, addr, size, strobe, data}`.
- `cbus_resp` in `cbus_resp_t`: `{addr_ok, data_ok, data[63:0]}`.

## Operation
- States:
  - IDLE: no transaction.
  - ADDR: `cbus_req.valid` high, waiting for `addr_ok`.
  - DATA: waiting for `data_ok`.
  - RESP: one-cycle response to the owner.
- Owner register: `owner ∈ {IBUS, DBUS}`. It is latched on leaving IDLE and is fixed until the state returns to IDLE.
- Arbitration (IDLE only):
  - dbus valid and ibus not valid: grant DBUS.
  - ibus valid and dbus not valid: grant IBUS.
  - Both valid: grant DBUS, unless `wait_cnt == MAX_WAIT`, then grant IBUS.
- `wait_cnt` (`$clog2(MAX_WAIT+1)` bits):
  - Increments when both requesters are valid in IDLE and DBUS is granted.
  - Clears whenever IBUS is granted.
  - Saturates at `MAX_WAIT`.
- Request translation for ibus: `is_write=0`, `size=MSIZE4`, `strobe=0`, `addr=ibus_req.addr`.
- Request fields are registered into `cbus_req` on the grant and held stable through ADDR.
- In ADDR, `cbus_resp.addr_ok` moves to DATA and drops `cbus_req.valid` the same edge. If `addr_ok` and `data_ok` arrive together, go straight to RESP.
- In DATA, `cbus_resp.data_ok` captures data and moves to RESP.
- RESP:
  - Owner's resp gets `addr_ok=1`, `data_ok=1`, captured data for exactly one cycle; the other requester's resp is all zero.
  - Next state is IDLE; no new grant in the RESP cycle.
- For ibus, data is `cbus data[31:0]` when `addr[2]==0`, else `[63:32]`.
- Flush:
  - `ibus_flush` in ADDR/DATA with owner IBUS sets `drop`. The transaction still completes on cbus; it is never abandoned. In RESP, `ibus_resp` stays zero if `drop`.
  - `drop` clears in IDLE.
  - `ibus_flush` in IDLE has no effect; the new ibus address is arbitrated normally.
- Requester valid falling mid-transaction is ignored; the transaction completes.
- Reset (`rst==0`, sampled on `clk`):
  - State IDLE, `owner=IBUS`, `wait_cnt=0`, `drop=0`.
  - `cbus_req` all zero.
  - `ibus_resp` and `dbus_resp` all zero.
- Reset mid-transaction abandons it silently. Downstream is reset by the same `rst`.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Minimum latency with `addr_ok` and `data_ok` both at the first ADDR cycle:
  - Request sampled in cycle N.
  - `cbus_req.valid` in N+1.
  - Owner resp in N+2.
  - Requester may issue again, sampled N+3.
- General case: resp is 1 cycle after the cycle `data_ok` is seen.
- Back-to-back: next grant is sampled in the cycle after RESP.
- Worst-case ibus wait under continuous dbus traffic is `MAX_WAIT` dbus transactions.

## Structure
- `common` package holds:
  - `cbus_req_t`, `cbus_resp_t`, `dbus_req_t`, `dbus_resp_t`.
  - Size encoding `MSIZE1/2/4/8`.
  - A state enum `arb_state_t {ARB_IDLE, ARB_ADDR, ARB_DATA, ARB_RESP}`.
  - `ibus_*` types already exist there.
- One sub-module, `arb_grant`: combinational grant plus `wait_cnt` register, taking `(ivalid, dvalid, in_idle)` and returning `grant_d`/`grant_i`. The FSM and datapath stay in the top.

## Test plan
- **Single ibus fetch.** Stimulus: ibus valid, addr=0x8000_0004; memory answers `addr_ok`+`data_ok` at once with data=0x1111_2222_3333_4444. Required: cbus valid at N+1 with `is_write=0`; `ibus_resp.data=0x1111_2222` at N+2 for one cycle.
- **Simultaneous requests.** Stimulus: ibus and dbus both valid (dbus write addr=0x100, strobe=0xFF). Required: dbus granted first; ibus granted in the cycle after the dbus RESP.
- **Starvation bound.** Stimulus: ibus held valid; dbus issues 6 back-to-back requests, `MAX_WAIT=4`. Required: ibus served after exactly 4 dbus transactions, then the remaining dbus requests proceed.
- **Flush in flight.** Stimulus: ibus granted; `ibus_flush` pulsed in DATA; `data_ok` arrives 3 cycles later. Required: cbus transaction completes; `ibus_resp` stays zero; a next ibus request to 0x200 is served normally.
- **Slow memory.** Stimulus: `addr_ok` delayed 2 cycles, then `data_ok` 5 cycles later. Required: `cbus_req` fields stable while valid; valid drops after `addr_ok`; resp one cycle after `data_ok`.
- **Reset mid-DATA.** Stimulus: `rst=0` for 1 cycle while in DATA. Required: next cycle all outputs zero, state IDLE, `wait_cnt=0`; a late `data_ok` is ignored.

Source files
------------

// File: rtl/common.sv
// common: shared memory-bus types used by the fetch, memory and cache-side ports.
//   ibus_req_t / ibus_resp_t : fetch request {valid, addr} and response {addr_ok, data_ok, data[31:0]}
//   dbus_req_t / dbus_resp_t : data request {valid, is_write, addr, size, strobe, data} and response
//   cbus_req_t / cbus_resp_t : downstream port, same layout as the dbus pair
package common;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [31:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef dbus_req_t  cbus_req_t;
    typedef dbus_resp_t cbus_resp_t;

    typedef enum logic [1:0] {ARB_IDLE, ARB_ADDR, ARB_DATA, ARB_RESP} arb_state_t;

    typedef enum logic {OWN_IBUS, OWN_DBUS} owner_t;

endpackage

// File: rtl/arb_grant.sv
// arb_grant: dbus-priority grant with a starvation counter that forces an ibus win.
//   clk, rst (sync, active-low) : clock and reset
//   ivalid, dvalid              : requester valids
//   in_idle                     : arbitration allowed this cycle
//   grant_d, grant_i            : one-hot grant (both low when not idle or nobody requests)
module arb_grant #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ivalid,
    input  logic dvalid,
    input  logic in_idle,
    output logic grant_d,
    output logic grant_i
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] wait_q, wait_d;
    logic          starved;

    always_comb begin
        starved = wait_q == CW'(MAX_WAIT);
        grant_i = in_idle && ivalid && (!dvalid || starved);
        grant_d = in_idle && dvalid && !grant_i;
        // counts only dbus wins that ibus actually contested
        wait_d  = grant_i ? '0 : (grant_d && ivalid && !starved) ? wait_q + 1'b1 : wait_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) wait_q <= '0;
        else      wait_q <= wait_d;
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one cbus port between ibus (fetch) and dbus (memory stage), one transaction at a time.
//   clk, rst (sync, active-low)    : clock and reset
//   ibus_req, ibus_flush, ibus_resp : fetch port; flush marks the in-flight fetch result stale
//   dbus_req, dbus_resp            : data port
//   cbus_req, cbus_resp            : downstream port toward cache/memory
// All outputs are registered.
module mem_bus_arbiter
    import common::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  ibus_req_t  ibus_req,
    input  logic       ibus_flush,
    output ibus_resp_t ibus_resp,
    input  dbus_req_t  dbus_req,
    output dbus_resp_t dbus_resp,
    output cbus_req_t  cbus_req,
    input  cbus_resp_t cbus_resp
);

    arb_state_t  state_q;
    owner_t      owner_q;
    logic        drop_q, drop_d, done, grant_d, grant_i;
    logic [31:0] iword;
    cbus_req_t   cbus_req_q;
    ibus_resp_t  ibus_resp_q;
    dbus_resp_t  dbus_resp_q;

    arb_grant #(.MAX_WAIT(MAX_WAIT)) u_grant (
        .clk     (clk),
        .rst     (rst),
        .ivalid  (ibus_req.valid),
        .dvalid  (dbus_req.valid),
        .in_idle (state_q == ARB_IDLE),
        .grant_d (grant_d),
        .grant_i (grant_i)
    );

    always_comb begin
        drop_d = drop_q || (ibus_flush && owner_q == OWN_IBUS);
        // data_ok is only honoured once the address phase has been accepted
        done   = cbus_resp.data_ok && (state_q == ARB_DATA || (state_q == ARB_ADDR && cbus_resp.addr_ok));
        iword  = cbus_req_q.addr[2] ? cbus_resp.data[63:32] : cbus_resp.data[31:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ARB_IDLE;
            owner_q     <= OWN_IBUS;
            drop_q      <= 1'b0;
            cbus_req_q  <= '0;
            ibus_resp_q <= '0;
            dbus_resp_q <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    drop_q <= 1'b0;
                    if (grant_i) begin
                        owner_q    <= OWN_IBUS;
                        cbus_req_q <= '{valid: 1'b1, is_write: 1'b0, addr: ibus_req.addr,
                                        size: MSIZE4, strobe: '0, data: '0};
                        state_q    <= ARB_ADDR;
                    end else if (grant_d) begin
                        owner_q    <= OWN_DBUS;
                        cbus_req_q <= dbus_req;
                        state_q    <= ARB_ADDR;
                    end
                end
                ARB_ADDR, ARB_DATA: begin
                    drop_q <= drop_d;
                    if (state_q == ARB_ADDR && cbus_resp.addr_ok) begin
                        cbus_req_q.valid <= 1'b0;
                        state_q          <= ARB_DATA;
                    end
                    if (done) begin
                        state_q <= ARB_RESP;
                        if (owner_q == OWN_IBUS)
                            ibus_resp_q <= drop_d ? '0 : '{addr_ok: 1'b1, data_ok: 1'b1, data: iword};
                        else
                            dbus_resp_q <= '{addr_ok: 1'b1, data_ok: 1'b1, data: cbus_resp.data};
                    end
                end
                default: begin
                    ibus_resp_q <= '0;
                    dbus_resp_q <= '0;
                    state_q     <= ARB_IDLE;
                end
            endcase
        end
    end

    assign cbus_req  = cbus_req_q;
    assign ibus_resp = ibus_resp_q;
    assign dbus_resp = dbus_resp_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: random requesters and memory checked against a transaction-level model of the arbiter.
module tb_mem_bus_arbiter;
    import common::*;

    logic       clk = 1'b0;
    logic       rst;
    ibus_req_t  ibus_req;
    logic       ibus_flush;
    ibus_resp_t ibus_resp;
    dbus_req_t  dbus_req;
    dbus_resp_t dbus_resp;
    cbus_req_t  cbus_req;
    cbus_resp_t cbus_resp;

    int n_chk = 0, n_pass = 0;

    int          phase, wcnt;
    logic        own_i, drop, ibusy, dbusy, czero, flush_hit, dir;
    logic [63:0] dir_data;
    ibus_req_t   ireq;
    dbus_req_t   dreq;
    cbus_req_t   exp_c;
    ibus_resp_t  exp_ir;
    dbus_resp_t  exp_dr;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.MAX_WAIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .ibus_req   (ibus_req),
        .ibus_flush (ibus_flush),
        .ibus_resp  (ibus_resp),
        .dbus_req   (dbus_req),
        .dbus_resp  (dbus_resp),
        .cbus_req   (cbus_req),
        .cbus_resp  (cbus_resp)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        phase  = 0;
        wcnt   = 0;
        drop   = 1'b0;
        ibusy  = 1'b0;
        dbusy  = 1'b0;
        own_i  = 1'b0;
        czero  = 1'b1;
        exp_c  = '0;
        exp_ir = '0;
        exp_dr = '0;
    endtask

    task automatic observe();
        cbus_req_t o;
        o = cbus_req;
        if (own_i && !czero) o.data = '0;
        check("ibus_resp", 128'(ibus_resp), 128'(exp_ir));
        check("dbus_resp", 128'(dbus_resp), 128'(exp_dr));
        check("cbus_valid", 128'(cbus_req.valid), 128'(exp_c.valid));
        if (exp_c.valid || czero) check("cbus_req", 128'(o), 128'(exp_c));
    endtask

    task automatic respond();
        if (own_i)
            exp_ir = drop ? '0 : '{addr_ok: 1'b1, data_ok: 1'b1,
                                   data: exp_c.addr[2] ? cbus_resp.data[63:32] : cbus_resp.data[31:0]};
        else
            exp_dr = '{addr_ok: 1'b1, data_ok: 1'b1, data: cbus_resp.data};
        phase = 3;
    endtask

    task automatic step();
        logic gi, gd;
        rst = dir || $urandom_range(0, 299) != 0;
        if (!dir && !ibusy && !ireq.valid && $urandom_range(0, 3) != 0)
            ireq = '{valid: 1'b1, addr: $urandom & ~32'h3};
        if (!dir && !dbusy && !dreq.valid && $urandom_range(0, 3) != 0)
            dreq = '{valid: 1'b1, is_write: 1'($urandom), addr: $urandom,
                     size: msize_t'($urandom_range(0, 3)), strobe: 8'($urandom), data: {$urandom, $urandom}};
        ibus_flush = !dir && phase != 3 && $urandom_range(0, 7) == 0;
        flush_hit  = ibus_flush && (phase == 1 || phase == 2) && own_i;
        if (ibus_flush && ireq.valid) ireq.addr = $urandom & ~32'h3;
        ibus_req = ireq;
        if (ibusy) begin
            ibus_req.valid = 1'($urandom);
            ibus_req.addr  = $urandom;
        end
        dbus_req = dreq;
        if (dbusy) begin
            dbus_req.valid = 1'($urandom);
            dbus_req.addr  = $urandom;
            dbus_req.data  = {$urandom, $urandom};
        end
        cbus_resp.addr_ok = dir || 1'($urandom);
        cbus_resp.data_ok = dir || (phase == 1 ? cbus_resp.addr_ok && 1'($urandom) :
                                    phase == 2 ? $urandom_range(0, 2) == 0 : 1'($urandom));
        cbus_resp.data    = dir ? dir_data : {$urandom, $urandom};
        if (!rst) begin
            model_reset();
            return;
        end
        case (phase)
            0: begin
                drop = 1'b0;
                gi = ibus_req.valid && (!dbus_req.valid || wcnt == 4);
                gd = dbus_req.valid && !gi;
                if (gi) begin
                    wcnt  = 0;
                    own_i = 1'b1;
                    ibusy = 1'b1;
                    exp_c = '{valid: 1'b1, is_write: 1'b0, addr: ireq.addr, size: MSIZE4, strobe: '0, data: '0};
                    ireq.valid = 1'b0;
                end else if (gd) begin
                    if (ibus_req.valid && wcnt < 4) wcnt++;
                    own_i = 1'b0;
                    dbusy = 1'b1;
                    exp_c = dreq;
                    dreq.valid = 1'b0;
                end
                if (gi || gd) begin
                    phase = 1;
                    czero = 1'b0;
                end
            end
            1: begin
                if (flush_hit) drop = 1'b1;
                if (cbus_resp.addr_ok) begin
                    exp_c.valid = 1'b0;
                    if (cbus_resp.data_ok) respond();
                    else phase = 2;
                end
            end
            2: begin
                if (flush_hit) drop = 1'b1;
                if (cbus_resp.data_ok) respond();
            end
            default: begin
                exp_ir = '0;
                exp_dr = '0;
                ibusy  = 1'b0;
                dbusy  = 1'b0;
                phase  = 0;
            end
        endcase
    endtask

    initial begin
        rst        = 1'b0;
        ibus_flush = 1'b0;
        ibus_req   = '0;
        dbus_req   = '0;
        cbus_resp  = '0;
        ireq       = '0;
        dreq       = '0;
        dir        = 1'b0;
        dir_data   = 64'h1111_2222_3333_4444;
        model_reset();
        repeat (3) @(negedge clk);
        observe();
        dir  = 1'b1;
        ireq = '{valid: 1'b1, addr: 32'h8000_0004};
        step();
        @(negedge clk);
        observe();
        check("fetch_cbus_rd", 128'({cbus_req.valid, cbus_req.is_write}), 128'(2'b10));
        step();
        @(negedge clk);
        observe();
        check("fetch_data", 128'(ibus_resp), 128'({1'b1, 1'b1, 32'h1111_2222}));
        step();
        @(negedge clk);
        observe();
        dir = 1'b0;
        for (int t = 0; t < 6000; t++) begin
            step();
            @(negedge clk);
            observe();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
